// File: rtl/spi_coef_regbank_pkg.sv
// Shared constants for the SPI coefficient register bank: register map, read filler, pointer widths.
package spi_coef_pkg;

  localparam logic [6:0] ADDR_CONTROL    = 7'h00;
  localparam logic [6:0] ADDR_STATUS     = 7'h01;
  localparam logic [6:0] ADDR_TAP_PTR    = 7'h02;
  localparam logic [6:0] ADDR_FILTER_PTR = 7'h03;
  localparam logic [6:0] ADDR_COEF_LSB   = 7'h04;
  localparam logic [6:0] ADDR_COEF_MSB   = 7'h05;
  localparam logic [6:0] ADDR_AUX        = 7'h06;
  localparam logic [6:0] ADDR_TEST       = 7'h07;
  localparam logic [6:0] ADDR_MOTOR      = 7'h08;
  localparam logic [6:0] ADDR_COMMIT     = 7'h09;

  localparam logic [7:0] READ_DEFAULT = 8'hAD;

  // Index width that never collapses to zero bits for single-entry dimensions.
  function automatic int unsigned ptr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_coef_regbank_if.sv
// Register strobe bus between the SPI front end (master) and the register bank (slave).
interface spi_reg_if;
  logic       wr_stb;
  logic       rd_stb;
  logic [6:0] addr;
  logic [7:0] wr_data;
  logic [7:0] rd_data;

  modport master (output wr_stb, rd_stb, addr, wr_data, input rd_data);
  modport slave  (input wr_stb, rd_stb, addr, wr_data, output rd_data);
endinterface

// File: rtl/spi_coef_regbank_ram.sv
// Two-bank FIR coefficient store; registered engine read port.
// COEF_READBACK_EN adds a combinational readback port for SPI reads.
module coef_bank_ram
  import spi_coef_pkg::*;
#(
  parameter int unsigned TAPS    = 8,
  parameter int unsigned FILTERS = 4,
  parameter int unsigned COEF_W  = 16,
  localparam int unsigned TW     = ptr_w(TAPS),
  localparam int unsigned FW     = ptr_w(FILTERS)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_wr_en,
  input  logic              i_wr_bank,
  input  logic [FW-1:0]     i_wr_filter,
  input  logic [TW-1:0]     i_wr_tap,
  input  logic [COEF_W-1:0] i_wr_data,
  input  logic              i_rd_bank,
  input  logic [FW-1:0]     i_rd_filter,
  input  logic [TW-1:0]     i_rd_tap,
`ifdef COEF_READBACK_EN
  input  logic              i_rb_bank,
  input  logic [FW-1:0]     i_rb_filter,
  input  logic [TW-1:0]     i_rb_tap,
  output logic [COEF_W-1:0] o_rb_data,
`endif
  output logic [COEF_W-1:0] o_rd_data
);

  logic [COEF_W-1:0] r_mem [2][FILTERS][TAPS];
  logic [COEF_W-1:0] r_rd_data;

  // Storage is intentionally not reset.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_bank][i_wr_filter][i_wr_tap] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= r_mem[i_rd_bank][i_rd_filter][i_rd_tap];
    end
  end

  assign o_rd_data = r_rd_data;

`ifdef COEF_READBACK_EN
  assign o_rb_data = r_mem[i_rb_bank][i_rb_filter][i_rb_tap];
`endif

endmodule

// File: rtl/spi_coef_regbank.sv
// SPI register bank with double-buffered FIR coefficients; swap deferred to sample_stb.
// Optional COEF_READBACK_EN: SPI readback of shadow coefficients via 0x04/0x05.
module spi_coef_regbank
  import spi_coef_pkg::*;
#(
  parameter int unsigned TAPS    = 8,
  parameter int unsigned FILTERS = 4,
  parameter int unsigned COEF_W  = 16,
  localparam int unsigned TW     = ptr_w(TAPS),
  localparam int unsigned FW     = ptr_w(FILTERS)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  spi_reg_if.slave          i_spi,
  input  logic [5:0]        i_status,
  output logic [7:0]        o_control_reg,
  output logic [7:0]        o_aux_port,
  output logic [7:0]        o_test_port,
  output logic [7:0]        o_motor_interval,
  input  logic              i_sample_stb,
  input  logic [FW-1:0]     i_coef_rd_filter,
  input  logic [TW-1:0]     i_coef_rd_tap,
  output logic [COEF_W-1:0] o_coef_rd_data,
  output logic              o_active_bank,
  output logic              o_swap_pending
);

  logic [7:0]        r_control, r_aux, r_test, r_motor, r_lsb, r_rd_data;
  logic [TW-1:0]     r_tap, w_tap_nxt;
  logic [FW-1:0]     r_filter, w_filter_nxt;
  logic              r_active, r_pending;
  logic              w_wr, w_rd, w_coef_we, w_commit, w_adv;
  logic [15:0]       w_word16;
  logic [COEF_W-1:0] w_coef_wr;
  logic [7:0]        w_rd_val;

  assign w_wr      = i_spi.wr_stb;
  assign w_rd      = i_spi.rd_stb;
  assign w_coef_we = w_wr && (i_spi.addr == ADDR_COEF_MSB);
  assign w_commit  = w_wr && (i_spi.addr == ADDR_COMMIT);
  assign w_word16  = {i_spi.wr_data, r_lsb};
  assign w_coef_wr = w_word16[COEF_W-1:0];

`ifdef COEF_READBACK_EN
  logic [COEF_W-1:0] w_rb;
  assign w_adv = w_coef_we || (w_rd && (i_spi.addr == ADDR_COEF_MSB));
`else
  assign w_adv = w_coef_we;
`endif

  always_comb begin
    w_tap_nxt    = r_tap;
    w_filter_nxt = r_filter;
    if (w_adv) begin
      if (r_tap == TW'(TAPS - 1)) begin
        w_tap_nxt    = '0;
        w_filter_nxt = (r_filter == FW'(FILTERS - 1)) ? '0 : r_filter + 1'b1;
      end else begin
        w_tap_nxt = r_tap + 1'b1;
      end
    end
    // Out-of-range pointer writes are dropped; explicit writes beat auto-increment.
    if (w_wr && (i_spi.addr == ADDR_TAP_PTR) && (32'(i_spi.wr_data) < TAPS)) begin
      w_tap_nxt = i_spi.wr_data[TW-1:0];
    end
    if (w_wr && (i_spi.addr == ADDR_FILTER_PTR) && (32'(i_spi.wr_data) < FILTERS)) begin
      w_filter_nxt = i_spi.wr_data[FW-1:0];
    end
  end

  always_comb begin
    w_rd_val = READ_DEFAULT;
    case (i_spi.addr)
      ADDR_CONTROL:    w_rd_val = r_control;
      ADDR_STATUS:     w_rd_val = {r_pending, r_active, i_status};
      ADDR_TAP_PTR:    w_rd_val = 8'(r_tap);
      ADDR_FILTER_PTR: w_rd_val = 8'(r_filter);
      ADDR_AUX:        w_rd_val = r_aux;
      ADDR_TEST:       w_rd_val = r_test;
      ADDR_MOTOR:      w_rd_val = r_motor;
`ifdef COEF_READBACK_EN
      ADDR_COEF_LSB:   w_rd_val = w_rb[7:0];
      ADDR_COEF_MSB:   w_rd_val = 8'(w_rb >> 8);
`endif
      default:         w_rd_val = READ_DEFAULT;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_control <= '0;
      r_aux     <= '0;
      r_test    <= '0;
      r_motor   <= '0;
      r_lsb     <= '0;
      r_rd_data <= '0;
      r_tap     <= '0;
      r_filter  <= '0;
      r_active  <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      r_tap    <= w_tap_nxt;
      r_filter <= w_filter_nxt;
      if (w_rd) r_rd_data <= w_rd_val;
      if (w_wr) begin
        case (i_spi.addr)
          ADDR_CONTROL:  r_control <= i_spi.wr_data;
          ADDR_COEF_LSB: r_lsb     <= i_spi.wr_data;
          ADDR_AUX:      r_aux     <= i_spi.wr_data;
          ADDR_TEST:     r_test    <= i_spi.wr_data;
          ADDR_MOTOR:    r_motor   <= i_spi.wr_data;
          default:       ;
        endcase
      end
      // A commit landing on the swap cycle re-arms pending for the next boundary.
      if (i_sample_stb && r_pending) begin
        r_active  <= ~r_active;
        r_pending <= w_commit;
      end else if (w_commit) begin
        r_pending <= 1'b1;
      end
    end
  end

  coef_bank_ram #(
    .TAPS    (TAPS),
    .FILTERS (FILTERS),
    .COEF_W  (COEF_W)
  ) u_ram (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_wr_en     (w_coef_we),
    .i_wr_bank   (~r_active),
    .i_wr_filter (r_filter),
    .i_wr_tap    (r_tap),
    .i_wr_data   (w_coef_wr),
    .i_rd_bank   (r_active),
    .i_rd_filter (i_coef_rd_filter),
    .i_rd_tap    (i_coef_rd_tap),
`ifdef COEF_READBACK_EN
    .i_rb_bank   (~r_active),
    .i_rb_filter (r_filter),
    .i_rb_tap    (r_tap),
    .o_rb_data   (w_rb),
`endif
    .o_rd_data   (o_coef_rd_data)
  );

  assign i_spi.rd_data    = r_rd_data;
  assign o_control_reg    = r_control;
  assign o_aux_port       = r_aux;
  assign o_test_port      = r_test;
  assign o_motor_interval = r_motor;
  assign o_active_bank    = r_active;
  assign o_swap_pending   = r_pending;

endmodule

// File: tb/tb_spi_coef_regbank.sv
// Directed bench for spi_coef_regbank (default TAPS=8, FILTERS=4, COEF_W=16).
module tb_spi_coef_regbank;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  status_in;
  logic [7:0]  control_reg, aux_port, test_port, motor_interval;
  logic        sample_stb;
  logic [1:0]  coef_rd_filter;
  logic [2:0]  coef_rd_tap;
  logic [15:0] coef_rd_data;
  logic        active_bank, swap_pending;
  logic [7:0]  rd;
  int          n_total = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  spi_reg_if bus ();

  spi_coef_regbank dut (
    .i_clk            (clk),
    .i_reset          (reset),
    .i_spi            (bus),
    .i_status         (status_in),
    .o_control_reg    (control_reg),
    .o_aux_port       (aux_port),
    .o_test_port      (test_port),
    .o_motor_interval (motor_interval),
    .i_sample_stb     (sample_stb),
    .i_coef_rd_filter (coef_rd_filter),
    .i_coef_rd_tap    (coef_rd_tap),
    .o_coef_rd_data   (coef_rd_data),
    .o_active_bank    (active_bank),
    .o_swap_pending   (swap_pending)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] pat(input int f, input int t);
    return 16'(32'hC000 + f * 256 + t * 17);
  endfunction

  task automatic reg_wr(input logic [6:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.wr_stb = 1'b1; bus.addr = a; bus.wr_data = d;
    @(negedge clk);
    bus.wr_stb = 1'b0;
  endtask

  task automatic reg_rd(input logic [6:0] a, output logic [7:0] d);
    @(negedge clk);
    bus.rd_stb = 1'b1; bus.addr = a;
    @(negedge clk);
    bus.rd_stb = 1'b0;
    d = bus.rd_data;
  endtask

  task automatic rd_check(input string tag, input logic [6:0] a, input logic [7:0] exp);
    logic [7:0] d;
    reg_rd(a, d);
    check(tag, d, exp);
  endtask

  task automatic pulse_sample();
    @(negedge clk);
    sample_stb = 1'b1;
    @(negedge clk);
    sample_stb = 1'b0;
  endtask

  task automatic commit_with_sample();
    @(negedge clk);
    bus.wr_stb = 1'b1; bus.addr = 7'h09; bus.wr_data = 8'h00; sample_stb = 1'b1;
    @(negedge clk);
    bus.wr_stb = 1'b0; sample_stb = 1'b0;
  endtask

  task automatic coef_check(input string tag, input int f, input int t, input logic [15:0] exp);
    @(negedge clk);
    coef_rd_filter = 2'(f); coef_rd_tap = 3'(t);
    @(negedge clk);
    check(tag, coef_rd_data, exp);
  endtask

  task automatic load_word(input logic [7:0] lsb, input logic [7:0] msb);
    reg_wr(7'h04, lsb);
    reg_wr(7'h05, msb);
  endtask

  initial begin
    bus.wr_stb = 1'b0; bus.rd_stb = 1'b0; bus.addr = '0; bus.wr_data = '0;
    sample_stb = 1'b0; coef_rd_filter = '0; coef_rd_tap = '0; status_in = 6'h2A;
    repeat (3) @(negedge clk);
    check("rst_coef_rd_data", coef_rd_data, 0);
    check("rst_active_bank", active_bank, 0);
    check("rst_swap_pending", swap_pending, 0);
    check("rst_spi_rd_data", bus.rd_data, 0);
    check("rst_control_reg", control_reg, 0);
    reset = 1'b0;
    rd_check("rd_control", 7'h00, 8'h00);
    rd_check("rd_status", 7'h01, 8'h2A);
    rd_check("rd_unmapped", 7'h0A, 8'hAD);

    // Single word with pointer wrap into next filter.
    reg_wr(7'h02, 8'd7);
    reg_wr(7'h03, 8'd0);
    load_word(8'h34, 8'h12);
    rd_check("wrap_tap", 7'h02, 8'd0);
    rd_check("wrap_filter", 7'h03, 8'd1);

    // Full shadow load then commit.
    reg_wr(7'h02, 8'd0);
    reg_wr(7'h03, 8'd0);
    for (int f = 0; f < 4; f++) begin
      for (int t = 0; t < 8; t++) begin
        logic [15:0] w;
        w = pat(f, t);
        load_word(w[7:0], w[15:8]);
      end
    end
    rd_check("full_wrap_tap", 7'h02, 8'd0);
    rd_check("full_wrap_filter", 7'h03, 8'd0);
    reg_wr(7'h09, 8'hFF);
    check("commit_pending", swap_pending, 1);
    check("commit_no_swap", active_bank, 0);
    rd_check("rd_status_pending", 7'h01, 8'hAA);
    pulse_sample();
    check("swap_active", active_bank, 1);
    check("swap_pending_clr", swap_pending, 0);
    rd_check("rd_status_swapped", 7'h01, 8'h6A);
    coef_check("coef_1_0", 1, 0, pat(1, 0));
    coef_check("coef_0_7", 0, 7, pat(0, 7));
    coef_check("coef_3_7", 3, 7, pat(3, 7));
    coef_check("coef_2_5", 2, 5, pat(2, 5));

    // Shadow is now bank 0; write one word, commit, then commit again on the swap cycle.
    reg_wr(7'h02, 8'd3);
    reg_wr(7'h03, 8'd2);
    load_word(8'h5A, 8'hA5);
    reg_wr(7'h09, 8'h00);
    commit_with_sample();
    check("rearm_active", active_bank, 0);
    check("rearm_pending", swap_pending, 1);
    coef_check("coef_bank0_2_3", 2, 3, 16'hA55A);
    pulse_sample();
    check("rearm_swap_active", active_bank, 1);
    check("rearm_swap_pending", swap_pending, 0);
    coef_check("coef_bank1_2_3", 2, 3, pat(2, 3));

    // Commit on a sample cycle with nothing pending: no swap yet.
    commit_with_sample();
    check("cs_idle_active", active_bank, 1);
    check("cs_idle_pending", swap_pending, 1);
    pulse_sample();
    check("cs_idle_swap", active_bank, 0);
    pulse_sample();
    check("sample_no_pending", active_bank, 0);

    // Out-of-range pointer writes are ignored.
    reg_wr(7'h02, 8'd5);
    reg_wr(7'h02, 8'd8);
    rd_check("tap_oor", 7'h02, 8'd5);
    reg_wr(7'h03, 8'd2);
    reg_wr(7'h03, 8'd4);
    rd_check("filter_oor", 7'h03, 8'd2);

    // Same-cycle write and read returns the pre-write value.
    reg_wr(7'h00, 8'h55);
    @(negedge clk);
    bus.wr_stb = 1'b1; bus.rd_stb = 1'b1; bus.addr = 7'h00; bus.wr_data = 8'h66;
    @(negedge clk);
    bus.wr_stb = 1'b0; bus.rd_stb = 1'b0;
    check("wr_rd_same_cycle", bus.rd_data, 8'h55);
    check("control_port", control_reg, 8'h66);
    rd_check("rd_control_new", 7'h00, 8'h66);
    reg_wr(7'h06, 8'hA1);
    reg_wr(7'h07, 8'hB2);
    reg_wr(7'h08, 8'hC3);
    check("aux_port", aux_port, 8'hA1);
    check("test_port", test_port, 8'hB2);
    check("motor_port", motor_interval, 8'hC3);
    rd_check("rd_motor", 7'h08, 8'hC3);
    rd_check("rd_commit_wo", 7'h09, 8'hAD);

    // Readback path (active 0, shadow 1).
    reg_wr(7'h02, 8'd0);
    reg_wr(7'h03, 8'd0);
    load_word(8'h34, 8'h12);
    rd_check("tap_after_load", 7'h02, 8'd1);
    reg_wr(7'h02, 8'd0);
`ifdef COEF_READBACK_EN
    rd_check("rb_lsb", 7'h04, 8'h34);
    rd_check("rb_msb", 7'h05, 8'h12);
    rd_check("rb_tap_adv", 7'h02, 8'd1);
`else
    rd_check("rb_lsb_off", 7'h04, 8'hAD);
    rd_check("rb_msb_off", 7'h05, 8'hAD);
    rd_check("rb_tap_hold", 7'h02, 8'd0);
`endif
    reg_wr(7'h09, 8'h00);
    pulse_sample();
    coef_check("coef_1234", 0, 0, 16'h1234);

    // Reset mid-load: staged lsb, pointers and pending are discarded.
    reg_wr(7'h04, 8'h77);
    reg_wr(7'h02, 8'd3);
    reg_wr(7'h09, 8'h00);
    check("pre_rst_pending", swap_pending, 1);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("mid_rst_pending", swap_pending, 0);
    check("mid_rst_active", active_bank, 0);
    rd_check("mid_rst_tap", 7'h02, 8'd0);
    rd_check("mid_rst_aux", 7'h06, 8'h00);
    reg_wr(7'h05, 8'h99);
    reg_wr(7'h09, 8'h00);
    pulse_sample();
    coef_check("coef_lsb_cleared", 0, 0, 16'h9900);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_coef_regbank.md
# spi_coef_regbank

Parametrised SPI-side register bank that succeeds the fixed 8-tap × 4-filter register block, sitting between the rPi SPI front end (register strobes, address, data) and the audio datapath. It holds the general control registers and a double-buffered FIR coefficient store of FILTERS × TAPS words with auto-incrementing indirect access. Firmware loads the shadow bank; the bank swap is deferred to a filter-engine sample boundary so coefficients never change mid-sample.

## Interface
- TAPS, 8, taps per filter (2..256)
- FILTERS, 4, number of filters (1..16)
- COEF_W, 16, coefficient width (9..16); MSB-byte bits above COEF_W-8 ignored
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- wr_stb  in  1  one-cycle register write strobe from SPI front end
- rd_stb  in  1  one-cycle register read strobe
- spi_addr  in  7  register address
- spi_wr_data  in  8  write data
- spi_rd_data  out  8  read data, registered
- status_in  in  6  external status bits
- control_reg / aux_port / test_port / motor_interval  out  8 each  general registers
- sample_stb  in  1  filter-engine sample boundary pulse
- coef_rd_filter  in  clog2(FILTERS)  engine read filter index
- coef_rd_tap  in  clog2(TAPS)  engine read tap index
- coef_rd_data  out  COEF_W  active-bank coefficient, registered
- active_bank  out  1  bank currently used by the engine
- swap_pending  out  1  commit requested, swap not yet taken

## Operation
- Address map: 0x00 CONTROL RW; 0x01 STATUS RO = {swap_pending, active_bank, status_in}; 0x02 TAP_PTR RW; 0x03 FILTER_PTR RW; 0x04 COEF_LSB W; 0x05 COEF_MSB W; 0x06 AUX RW; 0x07 TEST RW; 0x08 MOTOR RW; 0x09 COMMIT W (data ignored).
- TAP_PTR/FILTER_PTR writes with value ≥ TAPS/FILTERS are ignored; pointer reads return zero-extended value.
- COEF_LSB write stages the low byte only. COEF_MSB write stores {msb, staged lsb} truncated to COEF_W into the shadow bank (≠ active_bank) at [FILTER_PTR][TAP_PTR], then auto-increments: tap+1; tap wraps TAPS-1→0 and filter+1; filter wraps FILTERS-1→0.
- COMMIT write sets swap_pending. On sample_stb with swap_pending=1: active_bank toggles, swap_pending clears. Shadow bank then holds the previous active set (no copy).
- Shadow writes while swap_pending=1 are allowed and land in the pending bank.
- Unmapped or write-only addresses read 0xAD.
- Reset: all general registers 0x00, pointers 0, staged lsb 0, active_bank 0, swap_pending 0, spi_rd_data 0x00, coef_rd_data 0. Coefficient storage is not reset.

## Timing
- Register write effective the cycle after wr_stb.
- spi_rd_data valid the cycle after rd_stb; held until the next rd_stb.
- wr_stb and rd_stb in the same cycle: write committed, read returns pre-write value.
- COMMIT write and sample_stb same cycle with swap_pending=0: pending set, no swap this cycle.
- COMMIT write and sample_stb same cycle with swap_pending=1: swap taken, swap_pending stays 1.
- coef_rd_data: 1-cycle latency from coef_rd_filter/tap; on the swap cycle the read uses the pre-swap bank, new bank from the next cycle.
- reset asserted mid-load discards the staged lsb and pointers; pending swap is cancelled.

## Configuration
- COEF_READBACK_EN defined: reads of 0x04/0x05 return low/high byte of the shadow-bank word at the current pointers; a 0x05 read auto-increments the pointers exactly as a write does.
- Not defined: 0x04/0x05 read 0xAD, pointers unaffected by reads; storage needs only the engine read port.

## Structure
- Package spi_coef_pkg: address constants, READ_DEFAULT = 8'hAD, pointer-width helpers.
- Sub-module coef_bank_ram: 2 × FILTERS × TAPS × COEF_W storage, one write port (bank, filter, tap), registered engine read port, optional second read port under COEF_READBACK_EN.

## Test plan
- Reset then read 0x00, 0x01, 0x0A -> 0x00, {00, status_in}, 0xAD.
- TAP_PTR=7, FILTER_PTR=0, write LSB 0x34, MSB 0x12 -> shadow[0][7]=0x1234, pointers become filter 1, tap 0.
- Load all 32 words, COMMIT, no sample_stb -> swap_pending=1, engine still reads bank 0; pulse sample_stb -> active_bank=1, coef_rd_data[1][0] matches load one cycle later.
- COMMIT on same cycle as sample_stb with pending already set -> active_bank toggles, swap_pending remains 1.
- Write TAP_PTR=8 (TAPS=8) -> read 0x02 returns previous value.
- With COEF_READBACK_EN: read 0x04, 0x05 at [0][0] -> 0x34/0x12 pattern, pointer advances to tap 1; without: both read 0xAD.
